// File: rtl/imem_uart_loader.sv
// UART program loader for the core's instruction memory: 8N1 receiver plus a framed-image writer.
// Optional checksum byte after the image is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_uart_loader #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int DEPTH_WORDS = 2048,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        uart_rx_i,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        core_rst_no,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int IDX_W        = $clog2(DEPTH_WORDS) + 1;
  localparam int BCNT_W       = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {
    L_IDLE, L_CNT0, L_CNT1, L_DATA, L_DONE, L_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , L_CHK
`endif
  } ld_state_e;

  // [1:0] synchronizer stages, [2] previous synchronized value for edge detection
  logic [2:0] rx_sync_q;
  logic       rx_s_d, rx_fall_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_sync_q <= 3'b111;
    else         rx_sync_q <= {rx_sync_q[1:0], uart_rx_i};
  end

  assign rx_s_d    = rx_sync_q[1];
  assign rx_fall_d = rx_sync_q[2] & ~rx_sync_q[1];

  rx_state_e         rx_state_q;
  logic [BCNT_W-1:0] rx_cnt_q;
  logic [2:0]        rx_bit_q;
  logic [7:0]        rx_shift_q;
  logic              byte_valid_q, frame_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          if (rx_fall_d) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == BCNT_W'(HALF_BIT - 1)) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s_d ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BCNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s_d, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BCNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt_q     <= '0;
            rx_state_q   <= RX_IDLE;
            byte_valid_q <= rx_s_d;
            frame_err_q  <= ~rx_s_d;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  ld_state_e        ld_state_q;
  logic [7:0]       cnt_lo_q;
  logic [IDX_W-1:0] n_q, k_q;
  logic [23:0]      word_q;
  logic [1:0]       byte_idx_q;
  logic [31:0]      tmo_q;
  logic             we_q, core_rst_q, busy_q, done_q, err_q;
  logic [31:0]      addr_q, wdata_q;
  logic             ld_idle_d, tmo_hit_d;
  logic [15:0]      n16_d;
  logic [IDX_W-1:0] k_inc_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       chk_q;
`endif

  assign ld_idle_d = (ld_state_q == L_IDLE) || (ld_state_q == L_DONE) || (ld_state_q == L_ERR);
  assign tmo_hit_d = !byte_valid_q && (tmo_q == 32'(TIMEOUT_CYC - 1));
  assign n16_d     = {rx_shift_q, cnt_lo_q};
  assign k_inc_d   = k_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_state_q <= L_IDLE;
      cnt_lo_q   <= '0;
      n_q        <= '0;
      k_q        <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      tmo_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (ld_idle_d) begin
        if (byte_valid_q && rx_shift_q == 8'hA5) begin
          ld_state_q <= L_CNT0;
          k_q        <= '0;
          byte_idx_q <= '0;
          tmo_q      <= '0;
          busy_q     <= 1'b1;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          core_rst_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_q      <= '0;
`endif
        end
      end else if (frame_err_q || tmo_hit_d) begin
        ld_state_q <= L_ERR;
        busy_q     <= 1'b0;
        err_q      <= 1'b1;
        core_rst_q <= 1'b0;
      end else begin
        tmo_q <= byte_valid_q ? '0 : tmo_q + 1'b1;
        if (byte_valid_q) begin
          case (ld_state_q)
            L_CNT0: begin
              cnt_lo_q   <= rx_shift_q;
              ld_state_q <= L_CNT1;
            end
            L_CNT1: begin
              if (32'(n16_d) > 32'(DEPTH_WORDS)) begin
                ld_state_q <= L_ERR;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
              end else if (n16_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                ld_state_q <= L_CHK;
`else
                ld_state_q <= L_DONE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                core_rst_q <= 1'b1;
`endif
              end else begin
                n_q        <= IDX_W'(n16_d);
                ld_state_q <= L_DATA;
              end
            end
            L_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              chk_q <= chk_q ^ rx_shift_q;
`endif
              if (byte_idx_q == 2'd3) begin
                we_q       <= 1'b1;
                addr_q     <= 32'({k_q, 2'b00});
                wdata_q    <= {rx_shift_q, word_q};
                k_q        <= k_inc_d;
                byte_idx_q <= '0;
                if (k_inc_d == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  ld_state_q <= L_CHK;
`else
                  ld_state_q <= L_DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  core_rst_q <= 1'b1;
`endif
                end
              end else begin
                word_q[8*byte_idx_q +: 8] <= rx_shift_q;
                byte_idx_q                <= byte_idx_q + 1'b1;
              end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            L_CHK: begin
              busy_q <= 1'b0;
              if (rx_shift_q == chk_q) begin
                ld_state_q <= L_DONE;
                done_q     <= 1'b1;
                core_rst_q <= 1'b1;
              end else begin
                ld_state_q <= L_ERR;
                err_q      <= 1'b1;
              end
            end
`endif
            default: ld_state_q <= L_ERR;
          endcase
        end
      end
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign core_rst_no  = core_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: serial byte streams checked against a byte-level frame model.
`timescale 1ns/1ps
module tb_imem_uart_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        we;
  logic [31:0] addr, wdata;
  logic        core_rst_n, busy, done, err;

  imem_uart_loader #(
    .CLK_FREQ_HZ(1000000),
    .BAUD(100000),
    .DEPTH_WORDS(2048),
    .TIMEOUT_CYC(500)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .uart_rx_i(rx),
    .imem_we_o(we),
    .imem_addr_o(addr),
    .imem_wdata_o(wdata),
    .core_rst_no(core_rst_n),
    .busy_o(busy),
    .done_o(done),
    .err_o(err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Model state: expected write queue and expected status flags
  logic [63:0] exp_q[$];
  logic [63:0] log_q[$];
  logic        m_busy = 0, m_done = 0, m_err = 0, m_core = 0;
  logic [8:0]  stim_q[$];   // bit 8 = drive a bad (0) stop bit

  task automatic model_fail();
    m_busy = 0; m_err = 1; m_core = 0;
  endtask

  task automatic model_ok();
    m_busy = 0; m_done = 1; m_core = 1;
  endtask

  task automatic model_run();
    bit          in_load = 0;
    int          phase = 0, n = 0, k = 0, nb = 0;
    logic [7:0]  lo = 0, x = 0, b;
    logic [31:0] w = 0;
    foreach (stim_q[i]) begin
      b = stim_q[i][7:0];
      if (!in_load) begin
        if (!stim_q[i][8] && b == 8'hA5) begin
          in_load = 1; phase = 0; k = 0; nb = 0; w = 0; x = 0;
          m_busy = 1; m_done = 0; m_err = 0; m_core = 0;
        end
      end else if (stim_q[i][8]) begin
        model_fail(); in_load = 0;
      end else begin
        case (phase)
          0: begin lo = b; phase = 1; end
          1: begin
            n = {b, lo};
            if (n > 2048) begin model_fail(); in_load = 0; end
            else if (n == 0) phase = 3;
            else phase = 2;
          end
          2: begin
            x ^= b;
            w |= 32'(b) << (8 * (nb % 4));
            nb++;
            if (nb % 4 == 0) begin
              exp_q.push_back({32'(k * 4), w});
              k++; w = 0;
              if (k == n) phase = 3;
            end
          end
          default: begin
            if (b == x) model_ok(); else model_fail();
            in_load = 0;
          end
        endcase
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (in_load && phase == 3) begin model_ok(); in_load = 0; end
`endif
      end
    end
    // A load left incomplete ends by timeout
    if (in_load) model_fail();
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [8:0] v);
    rx = 1'b0; tick(10);
    for (int i = 0; i < 8; i++) begin rx = v[i]; tick(10); end
    rx = ~v[8]; tick(10);
    rx = 1'b1; tick(20);
  endtask

  task automatic run_stim(input int idle_after);
    model_run();
    foreach (stim_q[i]) send_byte(stim_q[i]);
    tick(idle_after);
    stim_q.delete();
  endtask

  task automatic push_good_load();
    logic [7:0] img[11] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    foreach (img[i]) stim_q.push_back({1'b0, img[i]});
  endtask

  task automatic check_end(input string name);
    check(busy == m_busy, {name, " busy"}, 32'(busy), 32'(m_busy));
    check(done == m_done, {name, " done"}, 32'(done), 32'(m_done));
    check(err == m_err, {name, " err"}, 32'(err), 32'(m_err));
    check(core_rst_n == m_core, {name, " core_rst_n"}, 32'(core_rst_n), 32'(m_core));
    check(exp_q.size() == 0, {name, " pending writes"}, 32'(exp_q.size()), 32'd0);
    $display("%s: busy=%0b done=%0b err=%0b core_rst_n=%0b writes=%0d", name, busy, done, err, core_rst_n, log_q.size());
  endtask

  // Compare process: every cycle checks reset values or write strobes against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      check({we, addr, wdata, core_rst_n, busy, done, err} == '0, "reset outputs",
            {28'd0, we, core_rst_n, busy, done | err}, 32'd0);
    end else if (we) begin
      log_q.push_back({addr, wdata});
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected write addr", addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check(addr == e[63:32], "write addr", addr, e[63:32]);
        check(wdata == e[31:0], "write data", wdata, e[31:0]);
      end
    end
  end

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check_end("after reset");

    // Two-word program
    log_q.delete();
    push_good_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim_q.push_back(9'h030);
`endif
    run_stim(50);
    check_end("two-word load");
    check(log_q.size() == 2, "load1 write count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check(log_q[0] == {32'h0, 32'h00A00513}, "load1 word0", log_q[0][31:0], 32'h00A00513);
      check(log_q[1] == {32'h4, 32'h00100593}, "load1 word1", log_q[1][31:0], 32'h00100593);
    end

    // Leading junk ignored, empty image
    log_q.delete();
    stim_q = '{9'h000, 9'h0FF, 9'h0A5, 9'h000, 9'h000};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim_q.push_back(9'h000);
`endif
    run_stim(50);
    check_end("empty load");
    check(log_q.size() == 0 && done, "empty load no writes", 32'(log_q.size()), 32'd0);

    // Count above capacity
    log_q.delete();
    stim_q = '{9'h0A5, 9'h001, 9'h008};
    run_stim(50);
    check_end("oversize count");
    check(err && !core_rst_n, "oversize err", 32'(err), 32'd1);

    // Stall mid-word until timeout
    log_q.delete();
    stim_q = '{9'h0A5, 9'h001, 9'h000, 9'h011, 9'h022};
    run_stim(600);
    check_end("timeout");
    check(err && !busy && log_q.size() == 0, "timeout err", 32'(err), 32'd1);

    // Framing error mid-data, then recovery
    stim_q = '{9'h0A5, 9'h001, 9'h000, 9'h011, 9'h122};
    run_stim(50);
    check_end("framing error");
    push_good_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim_q.push_back(9'h030);
`endif
    run_stim(50);
    check_end("recovery load");

    // Reset after the second data byte discards the partial load
    stim_q = '{9'h0A5, 9'h002, 9'h000, 9'h013, 9'h005};
    model_run();
    foreach (stim_q[i]) send_byte(stim_q[i]);
    stim_q.delete();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    exp_q.delete();
    m_busy = 0; m_done = 0; m_err = 0; m_core = 0;
    tick(5);
    check_end("mid-load reset");
    log_q.delete();
    push_good_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim_q.push_back(9'h030);
`endif
    run_stim(50);
    check_end("load after reset");
    check(log_q.size() > 0 && log_q[0][63:32] == 32'h0, "post-reset first addr",
          log_q.size() > 0 ? log_q[0][63:32] : 32'hFFFF_FFFF, 32'h0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: words still written, load rejected
    log_q.delete();
    push_good_load();
    stim_q.push_back(9'h031);
    run_stim(50);
    check_end("bad checksum");
    check(log_q.size() == 2 && err && !core_rst_n, "bad checksum err", 32'(log_q.size()), 32'd2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- UART-fed writer for the core's instruction memory; the core's fetch port is the reader.
- Receives a framed program image over a serial line and writes it word-by-word into instruction memory.
- Holds the core in reset while a load is in progress.
- Sits beside the core at top level; `core_rst_no` is ANDed into the core's `rst_ni`.

Parameters:
- CLK_FREQ_HZ, 50000000, clk_i frequency.
- BAUD, 115200, serial bit rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD, integer floor.
- DEPTH_WORDS, 2048, instruction memory capacity in 32-bit words.
- TIMEOUT_CYC, 5000000, maximum idle cycles between bytes during a load.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- uart_rx_i  in  1  serial input; idle high; 8N1, LSB first
- imem_we_o  out  1  one-cycle write strobe to instruction memory
- imem_addr_o  out  32  byte address, word-aligned (word index*4)
- imem_wdata_o  out  32  word to write
- core_rst_no  out  1  active-low reset to core; 0 = core held in reset
- busy_o  out  1  load in progress
- done_o  out  1  last load completed successfully
- err_o  out  1  last load aborted

Behaviour:
- Reset (async, rst_ni=0):
  - All outputs 0.
  - Both FSMs enter IDLE; partial word and counters are cleared.
  - Core stays in reset until the first successful load.
  - Reset mid-load discards everything received.
- RX input:
  - uart_rx_i passes through a 2-FF synchronizer before use.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE→START on a synchronized falling edge.
  - START: wait CLKS_PER_BIT/2 cycles.
    - If the line is high, it was a glitch: return to IDLE.
    - Otherwise go to DATA.
  - DATA: sample 8 bits, one every CLKS_PER_BIT cycles.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Stop bit 1: one-cycle internal byte_valid with the data.
    - Stop bit 0: framing error, no byte_valid.
  - Return to IDLE in both cases.
- Loader FSM (L_IDLE, L_CNT0, L_CNT1, L_DATA, L_DONE, L_ERR):
  - L_IDLE / L_DONE / L_ERR: byte 0xA5 starts a load.
    - Clears address and word count.
    - Sets busy_o=1, done_o=0, err_o=0, core_rst_no=0.
    - Goes to L_CNT0.
    - All other bytes are ignored.
  - L_CNT0 / L_CNT1: receive the word count N, 16-bit little-endian.
    - If N > DEPTH_WORDS: go to L_ERR.
    - If N == 0: go to L_DONE (or L_CHK when CHECKSUM_EN is defined).
  - L_DATA: bytes assembled little-endian (first byte = bits 7:0).
    - On the 4th byte, the cycle after its byte_valid: imem_we_o=1 for exactly one cycle, with imem_addr_o = k*4 and imem_wdata_o = word.
    - Then k increments.
    - After word N-1 is written, go to L_DONE.
  - L_DONE: busy_o=0, done_o=1, core_rst_no=1.
  - L_ERR: busy_o=0, err_o=1, core_rst_no=0 (core stays in reset).
- Error conditions, any state except the three idle states:
  - Framing error → L_ERR.
  - TIMEOUT_CYC cycles without byte_valid → L_ERR.
  - The timeout counter resets on every byte_valid.
  - Words already written stay in memory; no rollback.
- imem_addr_o and imem_wdata_o hold their last values between strobes.
- Word index width is clog2(DEPTH_WORDS)+1; no wrap is possible because N is capped at DEPTH_WORDS.
- A framing error in L_IDLE, L_DONE or L_ERR is ignored.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the N*4 data bytes (or right after the count when N=0), the FSM enters L_CHK and expects one byte equal to the XOR of all data bytes (0x00 when N=0).
  - Match → L_DONE.
  - Mismatch → L_ERR.
  - The timeout also applies in L_CHK.
- Undefined: L_CHK does not exist; L_DATA goes directly to L_DONE.

Test Plan:
- Bench parameters: CLK_FREQ_HZ=1000000, BAUD=100000 (10 clk/bit), TIMEOUT_CYC=500.
- Send A5 02 00 13 05 A0 00 93 05 10 00 [+chk 0x30 if EN] → two imem_we_o pulses: (0x0, 0x00A00513), (0x4, 0x00100593); then done_o=1, core_rst_no=1, err_o=0.
- Send 00 FF A5 00 00 [+00] → no writes; the first two bytes are ignored; done_o=1.
- Send A5 01 08 → count 0x0801 > 2048 → err_o=1, core_rst_no=0, no writes.
- Send A5 01 00 11 22, then stay idle for 600 cycles → err_o=1, busy_o=0, no write strobe.
- Send a frame with the stop bit driven 0 mid-data → err_o=1; then a valid load from the first test → done_o=1, err_o=0.
- Assert rst_ni low for 3 cycles after the 2nd data byte, then send a full valid load → all outputs 0 during reset; the subsequent load writes from address 0x0.
- EN only: corrupt the checksum byte in the first test → both writes occur, then err_o=1, core_rst_no=0.
